// File: rtl/sysid_checker.sv
// Avalon-MM reader that fetches the system-ID and timestamp words and compares them with the build values.
// Optional: define SYSID_CHECKER_AUTOSTART_EN to run one check automatically after each reset release.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1648570666,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        master_address,
    output logic        master_read,
    input  logic        master_waitrequest,
    input  logic [31:0] master_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CMP, DONE} state_t;

    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        read_q, read_d, addr_q, addr_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
    logic        start_eff, start_go;

`ifdef SYSID_CHECKER_AUTOSTART_EN
    logic auto_q;

    // One-shot: set by reset, consumed on the first edge after reset releases.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) auto_q <= 1'b1;
        else       auto_q <= 1'b0;
    end

    assign start_eff = start | auto_q;
`else
    assign start_eff = start;
`endif

    // DONE only accepts a new start once done is visible, so busy and done never both read 0 mid-check.
    assign start_go = start_eff && (state_q == IDLE || (state_q == DONE && done_q));

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        read_d     = read_q;
        addr_d     = addr_q;
        done_d     = done_q;
        pass_d     = pass_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    done_d = 1'b1;
                    pass_d = id_ok_q & ts_ok_q & ~timeout_q;
                end
                if (start_go) begin
                    state_d   = RD_ID;
                    read_d    = 1'b1;
                    addr_d    = 1'b0;
                    cnt_d     = TO_LOAD;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                if (!master_waitrequest) begin
                    cnt_d = TO_LOAD;
                    if (state_q == RD_ID) begin
                        id_value_d = master_readdata;
                        state_d    = RD_TS;
                        addr_d     = 1'b1;
                    end else begin
                        ts_value_d = master_readdata;
                        state_d    = CMP;
                        read_d     = 1'b0;
                        addr_d     = 1'b0;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    // The stall that would take the counter to zero is the one that aborts.
                    if (cnt_q <= 16'd1) begin
                        cnt_d     = 16'd0;
                        timeout_d = 1'b1;
                        state_d   = DONE;
                        read_d    = 1'b0;
                        addr_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            CMP: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RD_ID) || (state_d == RD_TS) || (state_d == CMP) ||
                 (state_d == DONE && !done_d);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            read_q     <= 1'b0;
            addr_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign master_read    = read_q;
    assign master_address = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign id_ok          = id_ok_q;
    assign ts_ok          = ts_ok_q;
    assign timeout        = timeout_q;
    assign id_value       = id_value_q;
    assign ts_value       = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: a slave model with programmable stalls, a result model, and a done monitor.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1648570666;
    localparam int          TO     = 4;

    typedef struct {
        int          start_edge;
        int          lat;
        logic        pass, id_ok, ts_ok, timeout, ts_read;
        logic [31:0] idv, tsv;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        master_address, master_read;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_readdata = '0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .master_address(master_address), .master_read(master_read),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    int n_pass = 0, n_total = 0, cyc = 0;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    // Slave: word0/word1 are the two registers; stall_id/stall_ts wait states per read.
    logic [31:0] word0 = EXP_ID, word1 = EXP_TS;
    int          stall_id = 0, stall_ts = 0, stall_cnt = 0, ts_reads = 0;
    logic        prev_wr = 1'b0, prev_addr = 1'b0;

    always @(negedge clock) begin
        if (reset || !master_read) begin
            stall_cnt          = 0;
            master_waitrequest = 1'b0;
        end else begin
            if (prev_wr) check("addr_stable_in_stall", master_address, prev_addr);
            if (master_address) ts_reads++;
            if (stall_cnt < (master_address ? stall_ts : stall_id)) begin
                master_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                master_waitrequest = 1'b0;
                stall_cnt          = 0;
            end
            master_readdata = master_address ? word1 : word0;
        end
        prev_wr   = master_waitrequest && master_read && !reset;
        prev_addr = master_address;
    end

    // Reference model: captured words persist across checks until reset.
    exp_t        sb_q[$];
    logic [31:0] m_id = '0, m_ts = '0;

    function automatic exp_t model(input int st_edge);
        exp_t e;
        e.start_edge = st_edge;
        e.id_ok = 1'b0; e.ts_ok = 1'b0; e.timeout = 1'b1;
        e.ts_read = (stall_id < TO);
        if (stall_id >= TO) begin
            e.lat = TO + 1;
        end else if (stall_ts >= TO) begin
            m_id  = word0;
            e.lat = stall_id + TO + 2;
        end else begin
            m_id = word0; m_ts = word1;
            e.lat     = 4 + stall_id + stall_ts;
            e.timeout = 1'b0;
            e.id_ok   = (word0 == EXP_ID);
            e.ts_ok   = (word1 == EXP_TS);
        end
        e.pass = e.id_ok && e.ts_ok && !e.timeout;
        e.idv  = m_id;
        e.tsv  = m_ts;
        return e;
    endfunction

    // Monitor: every rising done retires one scoreboard entry.
    logic done_prev = 1'b0;
    always @(negedge clock) begin
        if (!reset && done && !done_prev) begin
            check("done_has_expect", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("latency", 64'(cyc - e.start_edge), 64'(e.lat));
                check("pass", pass, e.pass);
                check("id_ok", id_ok, e.id_ok);
                check("ts_ok", ts_ok, e.ts_ok);
                check("timeout", timeout, e.timeout);
                check("id_value", id_value, e.idv);
                check("ts_value", ts_value, e.tsv);
                check("ts_read_issued", ts_reads != 0, e.ts_read);
                check("busy_at_done", busy, 1'b0);
            end
        end
        done_prev = done;
    end

    task automatic wait_done();
        int k = 0;
        while (!done && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic run(input logic [31:0] w0, input logic [31:0] w1,
                       input int sid, input int sts, input bit extra_start);
        @(negedge clock);
        word0 = w0; word1 = w1; stall_id = sid; stall_ts = sts; ts_reads = 0;
        start = 1'b1;
        sb_q.push_back(model(cyc + 1));
        @(negedge clock);
        start = 1'b0;
        if (extra_start) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_done();
    endtask

    task automatic check_reset_outputs();
        check("rst_ctrl", {master_read, master_address, busy, done, pass, id_ok, ts_ok, timeout}, 8'h00);
        check("rst_id_value", id_value, 32'h0);
        check("rst_ts_value", ts_value, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        word0 = EXP_ID; word1 = EXP_TS; stall_id = 0; stall_ts = 0; ts_reads = 0;
        reset = 1'b0;
        m_id = '0; m_ts = '0;
`ifdef SYSID_CHECKER_AUTOSTART_EN
        sb_q.push_back(model(cyc + 1));
        @(negedge clock);
        wait_done();
`endif
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (3) @(negedge clock);
        release_reset();
        repeat (2) @(negedge clock);

        run(EXP_ID, EXP_TS, 0, 0, 1'b0);
        run(EXP_ID, 32'h6243_0000, 0, 0, 1'b0);
        run(EXP_ID, EXP_TS, 3, 3, 1'b1);
        run(32'hDEAD_BEEF, EXP_TS, 100, 0, 1'b0);
        run(EXP_ID, EXP_TS, 2, 100, 1'b0);
        run(EXP_ID, EXP_TS, TO - 1, 0, 1'b0);
        run(EXP_ID, EXP_TS, TO, 0, 1'b0);

        // Reset in the middle of the timestamp read.
        @(negedge clock);
        word0 = 32'h1234_5678; word1 = EXP_TS; stall_id = 0; stall_ts = 3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 20 && !(master_read && master_address); k++) @(negedge clock);
        check("reached_rd_ts", master_read && master_address, 1'b1);
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        release_reset();
        run(EXP_ID, EXP_TS, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int s0, s1;
            s0 = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            s1 = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            run($urandom_range(0, 1) ? EXP_ID : $urandom,
                $urandom_range(0, 1) ? EXP_TS : $urandom,
                s0, s1, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
